// File: rtl/decode_stage.sv
// Instruction decode stage: takes 4-byte words from fetch, cracks them into
// control fields, buffers them in a small FIFO for execute, and redirects
// fetch on an unconditional jump while discarding wrong-path words.
module decode_stage #(
   parameter int DEPTH    = 2,
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          instruction1,
   input  logic [7:0]          instruction2,
   input  logic [7:0]          instruction3,
   input  logic [7:0]          instruction4,
   input  logic                data_ready,
   output logic                working,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [2:0]          ex_class,
   output logic [3:0]          ex_alu_op,
   output logic [REG_BITS-1:0] ex_dst,
   output logic [REG_BITS-1:0] ex_src,
   output logic [15:0]         ex_imm,
   output logic                redirect_valid,
   output logic [15:0]         redirect_pc,
   input  logic                redirect_ack
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = 3 + 4 + 2 * REG_BITS + 16;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   localparam logic [2:0] CLS_NOP     = 3'd0;
   localparam logic [2:0] CLS_ALU_RR  = 3'd1;
   localparam logic [2:0] CLS_ALU_RI  = 3'd2;
   localparam logic [2:0] CLS_LOAD    = 3'd3;
   localparam logic [2:0] CLS_STORE   = 3'd4;
   localparam logic [2:0] CLS_JUMP    = 3'd5;
   localparam logic [2:0] CLS_PROC    = 3'd6;
   localparam logic [2:0] CLS_ILLEGAL = 3'd7;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]          state, state_n;
   logic                consumed, consumed_n;
   logic [CNT_W-1:0]    count, count_n;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [ENTRY_W-1:0]  mem [DEPTH];

   logic [2:0]          dec_class;
   logic [3:0]          dec_alu_op;
   logic                dec_jmp;
   logic [ENTRY_W-1:0]  dec_entry;
   logic [ENTRY_W-1:0]  head;

   logic fresh, deq, room, enq, drop, take;

   // Crack the opcode byte into class and ALU sub-op.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      dec_class  = CLS_ILLEGAL;
      dec_alu_op = 4'd0;
      dec_jmp    = 1'b0;
      if (instruction1 == 8'h00) begin
         dec_class = CLS_NOP;
      end else if (instruction1[7:4] == 4'h0) begin
         dec_class  = CLS_ALU_RR;
         dec_alu_op = instruction1[3:0];
      end else if (instruction1[7:4] == 4'h1) begin
         dec_class  = CLS_ALU_RI;
         dec_alu_op = instruction1[3:0];
      end else begin
         case (instruction1)
            8'h20:   dec_class = CLS_LOAD;
            8'h21:   dec_class = CLS_STORE;
            8'h30: begin
               dec_class = CLS_JUMP;
               dec_jmp   = 1'b1;
            end
            8'h31: begin
               dec_class  = CLS_JUMP;
               dec_alu_op = 4'd1;
            end
            8'h40:   dec_class = CLS_PROC;
            default: dec_class = CLS_ILLEGAL;
         endcase
      end
   end

   assign dec_entry = {dec_class, dec_alu_op, instruction2[7 -: REG_BITS],
                       instruction4[REG_BITS-1:0], instruction3, instruction4};

   // A dequeue in the same cycle frees a slot, so a full FIFO can still take a word.
   assign ex_valid = (count != '0);
   assign fresh    = data_ready && !consumed;
   assign deq      = ex_valid && ex_ready;
   assign room     = (count != FULL_COUNT) || deq;
   assign enq      = fresh && (state == ST_RUN) && room;
   assign drop     = fresh && (state == ST_FLUSH);
   assign take     = enq || drop;

   // Next-state for the handshake, the FIFO occupancy and the redirect FSM.
   always_comb begin
      count_n = count;
      case ({enq, deq})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase

      consumed_n = consumed;
      if (!data_ready) consumed_n = 1'b0;
      else if (take)   consumed_n = 1'b1;

      state_n = state;
      if (state == ST_RUN && enq && dec_jmp)         state_n = ST_FLUSH;
      else if (state == ST_FLUSH && redirect_ack)    state_n = ST_RUN;
   end

   // Control state, pointers and the registered backpressure flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_RUN;
         consumed       <= 1'b0;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         working        <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 16'h0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state    <= state_n;
         consumed <= consumed_n;
         count    <= count_n;
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         working  <= (count_n == FULL_COUNT) || (state_n == ST_FLUSH) || (fresh && !take);
         if (state == ST_RUN && enq && dec_jmp) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= {instruction3, instruction4};
         end else if (state == ST_FLUSH && redirect_ack) begin
            redirect_valid <= 1'b0;
         end
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; occupancy is tracked by count and the outputs are masked while empty.
      if (enq) mem[wr_ptr] <= dec_entry;
   end

   // Head of FIFO, forced to zero while nothing is queued.
   assign head = ex_valid ? mem[rd_ptr] : '0;
   assign {ex_class, ex_alu_op, ex_dst, ex_src, ex_imm} = head;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected ops into a
// scoreboard queue; a monitor pops and compares on every execute handshake.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  instruction1 = 8'h00, instruction2 = 8'h00;
   logic [7:0]  instruction3 = 8'h00, instruction4 = 8'h00;
   logic        data_ready = 1'b0;
   logic        working;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [2:0]  ex_class;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_dst, ex_src;
   logic [15:0] ex_imm;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        redirect_ack = 1'b0;

   typedef struct {
      logic [2:0]  cls;
      logic [3:0]  alu;
      logic [4:0]  dst;
      logic [4:0]  src;
      logic [15:0] imm;
   } op_t;

   op_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;

   decode_stage #(.DEPTH(2), .REG_BITS(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .instruction1   (instruction1),
      .instruction2   (instruction2),
      .instruction3   (instruction3),
      .instruction4   (instruction4),
      .data_ready     (data_ready),
      .working        (working),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_class       (ex_class),
      .ex_alu_op      (ex_alu_op),
      .ex_dst         (ex_dst),
      .ex_src         (ex_src),
      .ex_imm         (ex_imm),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ack   (redirect_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_op(input logic [2:0] cls, input logic [3:0] alu,
                            input logic [4:0] dst, input logic [4:0] src,
                            input logic [15:0] imm);
      op_t o;
      o.cls = cls; o.alu = alu; o.dst = dst; o.src = src; o.imm = imm;
      exp_q.push_back(o);
   endtask

   task automatic set_word(input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
      instruction1 = b1; instruction2 = b2; instruction3 = b3; instruction4 = b4;
   endtask

   // Present a word for 'hold' edges, then drop data_ready for one edge.
   task automatic present(input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input int hold);
      set_word(b1, b2, b3, b4);
      data_ready = 1'b1;
      step(hold);
      data_ready = 1'b0;
      step(1);
   endtask

   // Scoreboard monitor: sample on the falling edge, compare each op execute takes.
   always @(negedge clk) begin
      if (rst && ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_op: class %0d imm 0x%0h with empty scoreboard", ex_class, ex_imm);
         end else begin
            op_t e;
            e = exp_q.pop_front();
            check("op_class", 32'(ex_class),  32'(e.cls));
            check("op_alu",   32'(ex_alu_op), 32'(e.alu));
            check("op_dst",   32'(ex_dst),    32'(e.dst));
            check("op_src",   32'(ex_src),    32'(e.src));
            check("op_imm",   32'(ex_imm),    32'(e.imm));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(2);
      check("rst_ex_valid", 32'(ex_valid), 0);
      check("rst_working",  32'(working), 0);
      check("rst_redir_v",  32'(redirect_valid), 0);
      check("rst_redir_pc", 32'(redirect_pc), 0);
      check("rst_ex_class", 32'(ex_class), 0);
      check("rst_ex_imm",   32'(ex_imm), 0);
      @(negedge clk);
      rst = 1'b1;
      step(1);

      // Single word held high for three edges is taken exactly once.
      ex_ready = 1'b1;
      expect_op(3'd2, 4'd2, 5'd5, 5'h1F, 16'h007F);
      set_word(8'h12, 8'h28, 8'h00, 8'h7F);
      data_ready = 1'b1;
      check("t1_pre_valid", 32'(ex_valid), 0);
      step(1);
      check("t1_valid_after_accept", 32'(ex_valid), 1);
      step(2);
      check("t1_no_reaccept", 32'(ex_valid), 0);
      data_ready = 1'b0;
      step(1);

      // Backpressure: two queue, the third waits, then all drain in order.
      ex_ready = 1'b0;
      expect_op(3'd1, 4'd1, 5'd1, 5'd3, 16'h0003);
      expect_op(3'd3, 4'd0, 5'd2, 5'd0, 16'h0100);
      expect_op(3'd4, 4'd0, 5'd3, 5'd4, 16'h0004);
      present(8'h01, 8'h08, 8'h00, 8'h03, 1);
      check("t2_working_one", 32'(working), 0);
      set_word(8'h20, 8'h10, 8'h01, 8'h00);
      data_ready = 1'b1;
      step(1);
      check("t2_working_full", 32'(working), 1);
      data_ready = 1'b0;
      step(1);
      set_word(8'h21, 8'h18, 8'h00, 8'h04);
      data_ready = 1'b1;
      step(2);
      check("t2_stalled_working", 32'(working), 1);
      check("t2_stalled_valid", 32'(ex_valid), 1);
      ex_ready = 1'b1;
      step(3);
      data_ready = 1'b0;
      step(2);
      check("t2_drained", 32'(exp_q.size()), 0);
      check("t2_empty_valid", 32'(ex_valid), 0);

      // JMP redirects fetch; wrong-path words dropped until ack.
      expect_op(3'd5, 4'd0, 5'd0, 5'd0, 16'h0140);
      present(8'h30, 8'h00, 8'h01, 8'h40, 1);
      check("t3_redir_valid", 32'(redirect_valid), 1);
      check("t3_redir_pc", 32'(redirect_pc), 32'h0140);
      check("t3_flush_working", 32'(working), 1);
      present(8'h01, 8'h08, 8'h00, 8'h01, 1);
      present(8'h02, 8'h10, 8'h00, 8'h02, 2);
      redirect_ack = 1'b1;
      step(1);
      redirect_ack = 1'b0;
      check("t3_redir_cleared", 32'(redirect_valid), 0);
      check("t3_run_working", 32'(working), 0);
      expect_op(3'd1, 4'd5, 5'd4, 5'd9, 16'h0009);
      present(8'h05, 8'h20, 8'h00, 8'h09, 1);
      // Ack arriving together with a new word: the word is dropped.
      expect_op(3'd5, 4'd0, 5'd0, 5'd0, 16'h0200);
      present(8'h30, 8'h00, 8'h02, 8'h00, 1);
      check("t3b_redir_pc", 32'(redirect_pc), 32'h0200);
      set_word(8'h06, 8'h28, 8'h00, 8'h0A);
      data_ready   = 1'b1;
      redirect_ack = 1'b1;
      step(1);
      redirect_ack = 1'b0;
      check("t3b_redir_cleared", 32'(redirect_valid), 0);
      step(1);
      data_ready = 1'b0;
      step(2);
      check("t3_drained", 32'(exp_q.size()), 0);

      // ILLEGAL passes imm through; JZ is class JUMP with no redirect.
      expect_op(3'd7, 4'd0, 5'd7, 5'h0D, 16'hABCD);
      present(8'hFF, 8'h38, 8'hAB, 8'hCD, 1);
      expect_op(3'd5, 4'd1, 5'd0, 5'h10, 16'h0010);
      present(8'h31, 8'h00, 8'h00, 8'h10, 1);
      check("t4_jz_no_redirect", 32'(redirect_valid), 0);
      step(2);
      check("t4_drained", 32'(exp_q.size()), 0);

      // Full FIFO: enqueue and dequeue on the same edge keeps count at DEPTH.
      ex_ready = 1'b0;
      expect_op(3'd1, 4'd3, 5'd6, 5'd1, 16'h0001);
      expect_op(3'd2, 4'd1, 5'd8, 5'h14, 16'h1234);
      expect_op(3'd6, 4'd0, 5'd9, 5'd0, 16'h0000);
      present(8'h03, 8'h30, 8'h00, 8'h01, 1);
      present(8'h11, 8'h40, 8'h12, 8'h34, 1);
      check("t5_full_working", 32'(working), 1);
      set_word(8'h40, 8'h48, 8'h00, 8'h00);
      data_ready = 1'b1;
      ex_ready   = 1'b1;
      step(1);
      ex_ready = 1'b0;
      check("t5_still_full", 32'(working), 1);
      check("t5_valid", 32'(ex_valid), 1);
      step(1);
      check("t5_no_extra", 32'(working), 1);
      data_ready = 1'b0;
      ex_ready   = 1'b1;
      step(4);
      check("t5_drained", 32'(exp_q.size()), 0);

      // Asynchronous reset in FLUSH with two ops queued.
      ex_ready = 1'b0;
      present(8'h04, 8'h50, 8'h00, 8'h00, 1);
      present(8'h30, 8'h00, 8'h00, 8'h80, 1);
      check("t6_pre_redir", 32'(redirect_valid), 1);
      #3;
      rst = 1'b0;
      #1;
      check("t6_rst_valid", 32'(ex_valid), 0);
      check("t6_rst_redir", 32'(redirect_valid), 0);
      check("t6_rst_working", 32'(working), 0);
      check("t6_rst_pc", 32'(redirect_pc), 0);
      @(negedge clk);
      rst = 1'b1;
      step(1);
      ex_ready = 1'b1;
      expect_op(3'd1, 4'hF, 5'd31, 5'd31, 16'hFFFF);
      present(8'h0F, 8'hF8, 8'hFF, 8'hFF, 1);
      step(3);
      check("final_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
